// File: rtl/axi_pkg.sv
// Shared AXI drain-gate types: gate state encoding and minimal AXI channel structs.
package axi_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } drain_state_e;

    // Upstream-to-downstream handshake and payload fields the gate acts on.
    typedef struct packed {
        logic       aw_valid;
        logic [7:0] aw_addr;
        logic       w_valid;
        logic [7:0] w_data;
        logic       w_last;
        logic       b_ready;
        logic       ar_valid;
        logic [7:0] ar_addr;
        logic       r_ready;
    } axi_req_t;

    // Downstream-to-upstream handshake and payload fields the gate acts on.
    typedef struct packed {
        logic       aw_ready;
        logic       w_ready;
        logic       b_valid;
        logic       ar_ready;
        logic       r_valid;
        logic [7:0] r_data;
        logic       r_last;
    } axi_resp_t;

endpackage

// File: rtl/axi_drain_cnt.sv
// Outstanding-transaction counter for one direction of the drain gate.
// Saturates at both ends so a stray response can never wrap the count.
module axi_drain_cnt #(
    parameter int  MaxTxns  = 8,
    localparam int CntWidth = $clog2(MaxTxns + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                dec,
    output logic                full,
    output logic                zero,
    output logic [CntWidth-1:0] count
);

    logic [CntWidth-1:0] count_next;
    logic                do_inc;
    logic                do_dec;

    assign full = (count == CntWidth'(MaxTxns));
    assign zero = (count == '0);

    // Simultaneous increment and decrement cancel; guarded ends keep the count in range.
    always_comb begin
        do_inc     = inc && !full;
        do_dec     = dec && !zero;
        count_next = count;
        if (do_inc && !do_dec) begin
            count_next = count + CntWidth'(1);
        end else if (do_dec && !do_inc) begin
            count_next = count - CntWidth'(1);
        end
    end

    // Count register, cleared by reset so in-flight accounting is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/axi_drain_gate.sv
// AXI drain gate: on isolate request, stops new AW/AR, lets outstanding
// traffic complete, then reports isolation. All data paths are combinational.
module axi_drain_gate
    import axi_pkg::*;
#(
    parameter int  MaxTxns = 8,
    parameter type req_t   = axi_req_t,
    parameter type resp_t  = axi_resp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  isolate_i,
    output logic  isolated_o,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  mst_req_o,
    input  resp_t mst_resp_i
);

    localparam int CntWidth = $clog2(MaxTxns + 1);

    drain_state_e        state;
    drain_state_e        next_state;
    logic                aw_pend;
    logic                ar_pend;
    logic                aw_pass;
    logic                ar_pass;
    logic                aw_stall;
    logic                ar_stall;
    logic                wr_inc;
    logic                wr_dec;
    logic                rd_inc;
    logic                rd_dec;
    logic                wr_full;
    logic                rd_full;
    logic                wr_zero;
    logic                rd_zero;
    logic                wr_drained;
    logic                rd_drained;
    logic [CntWidth-1:0] wr_count;
    logic [CntWidth-1:0] rd_count;

    // A valid forwarded downstream but not yet accepted must stay forwarded.
    assign aw_stall = mst_req_o.aw_valid && !mst_resp_i.aw_ready;
    assign ar_stall = mst_req_o.ar_valid && !mst_resp_i.ar_ready;

    assign wr_inc = mst_req_o.aw_valid && mst_resp_i.aw_ready;
    assign wr_dec = mst_resp_i.b_valid && mst_req_o.b_ready;
    assign rd_inc = mst_req_o.ar_valid && mst_resp_i.ar_ready;
    assign rd_dec = mst_resp_i.r_valid && mst_req_o.r_ready && mst_resp_i.r_last;

    // A direction is drained when its count will be zero after this cycle.
    assign wr_drained = !wr_inc && (wr_zero || (wr_count == CntWidth'(1) && wr_dec));
    assign rd_drained = !rd_inc && (rd_zero || (rd_count == CntWidth'(1) && rd_dec));

    axi_drain_cnt #(
        .MaxTxns (MaxTxns)
    ) u_wr_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (wr_inc),
        .dec   (wr_dec),
        .full  (wr_full),
        .zero  (wr_zero),
        .count (wr_count)
    );

    axi_drain_cnt #(
        .MaxTxns (MaxTxns)
    ) u_rd_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (rd_inc),
        .dec   (rd_dec),
        .full  (rd_full),
        .zero  (rd_zero),
        .count (rd_count)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= NORMAL;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: drain until both directions are empty and nothing is stalled.
    always_comb begin
        next_state = state;
        unique case (state)
            NORMAL: begin
                if (isolate_i) next_state = DRAIN;
            end
            DRAIN: begin
                if (!isolate_i) begin
                    next_state = NORMAL;
                end else if (wr_drained && rd_drained && !aw_stall && !ar_stall) begin
                    next_state = ISOLATED;
                end
            end
            ISOLATED: begin
                if (!isolate_i) next_state = NORMAL;
            end
            default: next_state = NORMAL;
        endcase
    end

    // Output logic: pass-through with AW/AR gating and W shut off while isolated.
    always_comb begin
        mst_req_o  = slv_req_i;
        slv_resp_o = mst_resp_i;
        aw_pass    = aw_pend || (state == NORMAL && !wr_full);
        ar_pass    = ar_pend || (state == NORMAL && !rd_full);
        mst_req_o.aw_valid  = slv_req_i.aw_valid && aw_pass;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && aw_pass;
        mst_req_o.ar_valid  = slv_req_i.ar_valid && ar_pass;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && ar_pass;
        if (state == ISOLATED) begin
            mst_req_o.w_valid  = 1'b0;
            slv_resp_o.w_ready = 1'b0;
        end
    end

    // Stall-pending flags and the registered isolation flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_pend    <= 1'b0;
            ar_pend    <= 1'b0;
            isolated_o <= 1'b0;
        end else begin
            aw_pend    <= aw_stall;
            ar_pend    <= ar_stall;
            isolated_o <= (next_state == ISOLATED);
        end
    end

endmodule
